// File: rtl/vlg_tick_gen.sv
// Timebase generator: us/ms/s tick pulses plus a programmable tick whose divide
// value is staged in a pending register and swapped in on a clean boundary.
module vlg_tick_gen #(
  parameter int P_CLK_PERIOD = 20,
  parameter int P_MS_DIV     = 1000,
  parameter int P_S_DIV      = 1000,
  parameter int P_DIV_W      = 16,
  parameter int P_PROG_DEF   = 10
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  input  logic               i_sync,
  input  logic               i_div_load,
  input  logic [P_DIV_W-1:0] i_div_val,
  output logic               o_tick_us,
  output logic               o_tick_ms,
  output logic               o_tick_s,
  output logic               o_tick_prog,
  output logic [P_DIV_W-1:0] o_div_active
);

  localparam int N    = 1000 / P_CLK_PERIOD;
  localparam int US_W = (N > 1) ? $clog2(N) : 1;
  localparam int MS_W = $clog2(P_MS_DIV);
  localparam int S_W  = $clog2(P_S_DIV);

  localparam logic [US_W-1:0]    US_MAX   = US_W'(N - 1);
  localparam logic [MS_W-1:0]    MS_MAX   = MS_W'(P_MS_DIV - 1);
  localparam logic [S_W-1:0]     S_MAX    = S_W'(P_S_DIV - 1);
  localparam logic [US_W-1:0]    US_ZERO  = {US_W{1'b0}};
  localparam logic [MS_W-1:0]    MS_ZERO  = {MS_W{1'b0}};
  localparam logic [S_W-1:0]     S_ZERO   = {S_W{1'b0}};
  localparam logic [P_DIV_W-1:0] DIV_ZERO = {P_DIV_W{1'b0}};
  localparam logic [P_DIV_W-1:0] DIV_ONE  = P_DIV_W'(1);
  localparam logic [P_DIV_W-1:0] DIV_DEF  = P_DIV_W'(P_PROG_DEF);

  logic [US_W-1:0]    us_cnt_r, us_cnt_n;
  logic [MS_W-1:0]    ms_cnt_r, ms_cnt_n;
  logic [S_W-1:0]     s_cnt_r, s_cnt_n;
  logic [P_DIV_W-1:0] prog_cnt_r, prog_cnt_n;
  logic [P_DIV_W-1:0] div_active_r, div_active_n;
  logic [P_DIV_W-1:0] div_pend_r, div_pend_n;
  logic               pend_r, pend_n;
  logic               tick_us_r, tick_us_n;
  logic               tick_ms_r, tick_ms_n;
  logic               tick_s_r, tick_s_n;
  logic               tick_prog_r, tick_prog_n;

  logic us_strobe_s, ms_wrap_s, s_wrap_s;
  logic prog_on_s, prog_wrap_s, apply_s, direct_s;

  assign us_strobe_s = i_en && (us_cnt_r == US_MAX);
  assign ms_wrap_s   = us_strobe_s && (ms_cnt_r == MS_MAX);
  assign s_wrap_s    = ms_wrap_s && (s_cnt_r == S_MAX);
  assign prog_on_s   = (div_active_r != DIV_ZERO);
  assign prog_wrap_s = us_strobe_s && prog_on_s && (prog_cnt_r == (div_active_r - DIV_ONE));
  // A pending value swaps in while the registered wrap is visible, on sync, or at once when the tick is off.
  assign apply_s     = pend_r && (i_sync || tick_prog_r || !prog_on_s);
  // With the programmable tick off and nothing staged, a load goes straight to active.
  assign direct_s    = i_div_load && !prog_on_s && !pend_r;

  // Next state of the fixed us/ms/s chain and its tick pulses
  always_comb begin
    us_cnt_n  = us_cnt_r;
    ms_cnt_n  = ms_cnt_r;
    s_cnt_n   = s_cnt_r;
    tick_us_n = 1'b0;
    tick_ms_n = 1'b0;
    tick_s_n  = 1'b0;
    if (i_sync) begin
      us_cnt_n = US_ZERO;
      ms_cnt_n = MS_ZERO;
      s_cnt_n  = S_ZERO;
    end else if (us_strobe_s) begin
      us_cnt_n  = US_ZERO;
      tick_us_n = 1'b1;
      if (ms_wrap_s) begin
        ms_cnt_n  = MS_ZERO;
        tick_ms_n = 1'b1;
        if (s_wrap_s) begin
          s_cnt_n  = S_ZERO;
          tick_s_n = 1'b1;
        end else begin
          s_cnt_n = s_cnt_r + S_W'(1);
        end
      end else begin
        ms_cnt_n = ms_cnt_r + MS_W'(1);
      end
    end else if (i_en) begin
      us_cnt_n = us_cnt_r + US_W'(1);
    end else begin
      us_cnt_n = us_cnt_r;
    end
  end

  // Next state of the programmable counter, active and pending divide values
  always_comb begin
    prog_cnt_n   = prog_cnt_r;
    div_active_n = div_active_r;
    div_pend_n   = div_pend_r;
    pend_n       = pend_r;
    tick_prog_n  = 1'b0;
    if (i_div_load) begin
      div_pend_n = i_div_val;
    end else begin
      div_pend_n = div_pend_r;
    end
    if (apply_s) begin
      div_active_n = div_pend_r;
      pend_n       = i_div_load;
    end else if (direct_s) begin
      div_active_n = i_div_val;
      pend_n       = 1'b0;
    end else if (i_div_load) begin
      pend_n = 1'b1;
    end else begin
      pend_n = pend_r;
    end
    if (i_sync || apply_s || direct_s || !prog_on_s) begin
      prog_cnt_n = DIV_ZERO;
    end else if (us_strobe_s) begin
      prog_cnt_n = prog_wrap_s ? DIV_ZERO : (prog_cnt_r + DIV_ONE);
    end else begin
      prog_cnt_n = prog_cnt_r;
    end
    if (i_sync) begin
      tick_prog_n = 1'b0;
    end else begin
      tick_prog_n = prog_wrap_s;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      us_cnt_r     <= US_ZERO;
      ms_cnt_r     <= MS_ZERO;
      s_cnt_r      <= S_ZERO;
      prog_cnt_r   <= DIV_ZERO;
      div_active_r <= DIV_DEF;
      div_pend_r   <= DIV_ZERO;
      pend_r       <= 1'b0;
      tick_us_r    <= 1'b0;
      tick_ms_r    <= 1'b0;
      tick_s_r     <= 1'b0;
      tick_prog_r  <= 1'b0;
    end else begin
      us_cnt_r     <= us_cnt_n;
      ms_cnt_r     <= ms_cnt_n;
      s_cnt_r      <= s_cnt_n;
      prog_cnt_r   <= prog_cnt_n;
      div_active_r <= div_active_n;
      div_pend_r   <= div_pend_n;
      pend_r       <= pend_n;
      tick_us_r    <= tick_us_n;
      tick_ms_r    <= tick_ms_n;
      tick_s_r     <= tick_s_n;
      tick_prog_r  <= tick_prog_n;
    end
  end

  assign o_tick_us    = tick_us_r;
  assign o_tick_ms    = tick_ms_r;
  assign o_tick_s     = tick_s_r;
  assign o_tick_prog  = tick_prog_r;
  assign o_div_active = div_active_r;

endmodule
